// File: rtl/obi_dma_pkg.sv
// ============================================================================
// Module   : obi_dma_pkg
// Purpose  : Shared types and constants for the OBI memory-to-memory DMA engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package obi_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  BE_ALL     = 4'hF;

endpackage

`default_nettype wire

// File: rtl/obi_dma_engine.sv
// ============================================================================
// Module   : obi_dma_engine
// Purpose  : Single-outstanding OBI initiator copying len words src -> dst.
//            Optional cycle counter enabled by defining OBI_DMA_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_dma_engine
  import obi_dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [31:0]          cycles_o,
  output logic                 obi_req,
  output logic                 obi_we,
  output logic [3:0]           obi_be,
  output logic [31:0]          obi_addr,
  output logic [31:0]          obi_wdata,
  input  logic                 obi_gnt,
  input  logic                 obi_rvalid,
  input  logic [31:0]          obi_rdata
);

  state_t               state;
  state_t               state_next;
  logic [31:0]          src_addr;
  logic [31:0]          dst_addr;
  logic [LEN_WIDTH-1:0] remaining;
  logic [31:0]          data_buf;
  logic                 err_flag;
  logic                 misaligned;

  assign misaligned = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      src_addr  <= '0;
      dst_addr  <= '0;
      remaining <= '0;
      data_buf  <= '0;
      err_flag  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            src_addr  <= src_addr_i;
            dst_addr  <= dst_addr_i;
            remaining <= len_i;
            err_flag  <= misaligned;
          end
        end
        ST_RD_WAIT: begin
          if (obi_rvalid) data_buf <= obi_rdata;
        end
        ST_WR_WAIT: begin
          // Write response retires the word; addresses wrap modulo 2^32.
          if (obi_rvalid) begin
            src_addr  <= src_addr + 32'(WORD_BYTES);
            dst_addr  <= dst_addr + 32'(WORD_BYTES);
            remaining <= remaining - LEN_WIDTH'(1);
          end
        end
        ST_DONE: begin
          err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          if (misaligned || (len_i == '0)) state_next = ST_DONE;
          else                             state_next = ST_RD_REQ;
        end
      end
      ST_RD_REQ:  if (obi_gnt)    state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (obi_rvalid) state_next = ST_WR_REQ;
      ST_WR_REQ:  if (obi_gnt)    state_next = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (obi_rvalid) begin
          if (remaining == LEN_WIDTH'(1)) state_next = ST_DONE;
          else                            state_next = ST_RD_REQ;
        end
      end
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Bus outputs depend only on state and registers, never on gnt/rvalid.
  always_comb begin
    obi_req   = 1'b0;
    obi_we    = 1'b0;
    obi_be    = 4'h0;
    obi_addr  = '0;
    obi_wdata = '0;
    case (state)
      ST_RD_REQ: begin
        obi_req  = 1'b1;
        obi_be   = BE_ALL;
        obi_addr = src_addr;
      end
      ST_WR_REQ: begin
        obi_req   = 1'b1;
        obi_we    = 1'b1;
        obi_be    = BE_ALL;
        obi_addr  = dst_addr;
        obi_wdata = data_buf;
      end
      default: ;
    endcase
  end

  assign busy_o = (state != ST_IDLE);
  assign done_o = (state == ST_DONE);
  assign err_o  = (state == ST_DONE) && err_flag;

`ifdef OBI_DMA_PERF_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (start_i) cycle_cnt <= '0;
    end else if (cycle_cnt != 32'hFFFF_FFFF) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign cycles_o = cycle_cnt;
`else
  assign cycles_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_obi_dma_engine.sv
// ============================================================================
// Module   : tb_obi_dma_engine
// Purpose  : Directed self-checking bench for obi_dma_engine with an OBI SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obi_dma_engine;

`ifdef OBI_DMA_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] src_addr_i = '0;
  logic [31:0] dst_addr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] cycles_o;
  logic        obi_req, obi_we, obi_gnt, obi_rvalid;
  logic [3:0]  obi_be;
  logic [31:0] obi_addr, obi_wdata, obi_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  obi_dma_engine #(.LEN_WIDTH(16)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .cycles_o   (cycles_o),
    .obi_req    (obi_req),
    .obi_we     (obi_we),
    .obi_be     (obi_be),
    .obi_addr   (obi_addr),
    .obi_wdata  (obi_wdata),
    .obi_gnt    (obi_gnt),
    .obi_rvalid (obi_rvalid),
    .obi_rdata  (obi_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h40) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // SRAM responder: 1024 words, gnt after cur_delay cycles, rvalid one cycle after gnt.
  logic [31:0] mem [1024];
  bit          rand_gnt = 1'b0;
  int          wait_cnt, cur_delay;
  int          acc_cnt = 0, req_cyc = 0, done_cnt = 0, stab_viol = 0;
  logic [31:0] log_addr [64];
  logic [31:0] log_wdata [64];
  logic [3:0]  log_be [64];
  logic        log_we [64];

  assign obi_gnt = obi_req && (!rand_gnt || (wait_cnt >= cur_delay));

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      obi_rvalid <= 1'b0;
      obi_rdata  <= '0;
      wait_cnt   <= 0;
      cur_delay  <= 0;
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else begin
      obi_rvalid <= 1'b0;
      if (obi_req && obi_gnt) begin
        obi_rvalid <= 1'b1;
        obi_rdata  <= obi_we ? 32'h0 : mem[obi_addr[11:2]];
        if (obi_we) mem[obi_addr[11:2]] <= obi_wdata;
        wait_cnt  <= 0;
        cur_delay <= rand_gnt ? int'($urandom_range(0, 3)) : 0;
        log_addr[acc_cnt[5:0]]  <= obi_addr;
        log_wdata[acc_cnt[5:0]] <= obi_wdata;
        log_be[acc_cnt[5:0]]    <= obi_be;
        log_we[acc_cnt[5:0]]    <= obi_we;
        acc_cnt <= acc_cnt + 1;
      end else if (obi_req) begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Protocol monitor: request held stable until gnt, no request while a response is pending.
  logic        p_pend = 1'b0, p_we;
  logic [3:0]  p_be;
  logic [31:0] p_addr, p_wdata;
  always @(posedge clk_i) begin
    if (rst_ni && p_pend &&
        !(obi_req && obi_we == p_we && obi_be == p_be && obi_addr == p_addr && obi_wdata == p_wdata))
      stab_viol <= stab_viol + 1;
    if (rst_ni && obi_req && obi_rvalid) stab_viol <= stab_viol + 1;
    p_pend  <= rst_ni && obi_req && !obi_gnt;
    p_we    <= obi_we;
    p_be    <= obi_be;
    p_addr  <= obi_addr;
    p_wdata <= obi_wdata;
    if (rst_ni && obi_req) req_cyc <= req_cyc + 1;
    if (rst_ni && done_o)  done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a command in cycle N; lat = k where done_o seen in cycle N+k (0 on timeout).
  // Returns at the negedge after the done cycle.
  task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input int budget, output int lat, output logic e);
    src_addr_i = s;
    dst_addr_i = d;
    len_i      = n;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 0;
    e   = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (done_o) begin
        lat = k;
        e   = err_o;
        break;
      end
      @(negedge clk_i);
    end
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  int   lat, base, rbase, dbase;
  logic e;
  bit   found;

  initial begin
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cycles", cycles_o, 0);
    chk("rst_req", obi_req, 0);
    chk("rst_we", obi_we, 0);
    chk("rst_be", obi_be, 0);
    chk("rst_addr", obi_addr, 0);
    chk("rst_wdata", obi_wdata, 0);

    // len = 0
    rbase = req_cyc;
    run_cmd(32'h100, 32'h200, 16'd0, 20, lat, e);
    chk("len0_lat", lat, 1);
    chk("len0_err", e, 0);
    chk("len0_noreq", req_cyc - rbase, 0);
    chk("len0_cycles", cycles_o, PERF ? 32'd1 : 32'd0);

    // single word copy, zero-wait
    base = acc_cnt;
    run_cmd(32'h100, 32'h200, 16'd1, 20, lat, e);
    chk("w1_lat", lat, 5);
    chk("w1_err", e, 0);
    chk("w1_nacc", acc_cnt - base, 2);
    chk("w1_rd_we", log_we[base], 0);
    chk("w1_rd_addr", log_addr[base], 32'h100);
    chk("w1_wr_we", log_we[base+1], 1);
    chk("w1_wr_addr", log_addr[base+1], 32'h200);
    chk("w1_wr_data", log_wdata[base+1], 32'hDEAD_BEEF);
    chk("w1_wr_be", log_be[base+1], 4'hF);
    chk("w1_mem", mem[32'h200 >> 2], 32'hDEAD_BEEF);
    chk("w1_cycles", cycles_o, PERF ? 32'd5 : 32'd0);

    // four words with random gnt delay
    rand_gnt = 1'b1;
    base  = acc_cnt;
    dbase = done_cnt;
    run_cmd(32'h100, 32'h200, 16'd4, 100, lat, e);
    rand_gnt = 1'b0;
    chk("w4_done_seen", lat != 0, 1);
    chk("w4_one_done", done_cnt - dbase, 1);
    chk("w4_nacc", acc_cnt - base, 8);
    for (int k = 0; k < 4; k++) begin
      chk("w4_rd_addr", log_addr[base+2*k], 32'h100 + 32'(4*k));
      chk("w4_wr_addr", log_addr[base+2*k+1], 32'h200 + 32'(4*k));
      chk("w4_wr_data", log_wdata[base+2*k+1], init_word(32'h40 + k));
      chk("w4_mem", mem[32'h80 + k], init_word(32'h40 + k));
    end
    chk("w4_stable", stab_viol, 0);

    // misaligned source
    rbase = req_cyc;
    run_cmd(32'h102, 32'h400, 16'd8, 20, lat, e);
    chk("mis_lat", lat, 1);
    chk("mis_err", e, 1);
    chk("mis_noreq", req_cyc - rbase, 0);
    chk("mis_cycles", cycles_o, PERF ? 32'd1 : 32'd0);
    run_cmd(32'h180, 32'h480, 16'd2, 40, lat, e);
    chk("after_mis_lat", lat, 9);
    chk("after_mis_err", e, 0);
    chk("after_mis_mem0", mem[32'h120], init_word(32'h60));
    chk("after_mis_mem1", mem[32'h121], init_word(32'h61));

    // start re-pulsed / held mid-transfer with other operands
    base = acc_cnt;
    src_addr_i = 32'h1C0;
    dst_addr_i = 32'h500;
    len_i      = 16'd3;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 0;
    for (int k = 1; k <= 64; k++) begin
      if (done_o) begin
        lat = k;
        break;
      end
      if (k == 3) begin
        start_i = 1'b1; src_addr_i = 32'h0; dst_addr_i = 32'h600; len_i = 16'd1;
      end
      if (k == 7) start_i = 1'b0;
      if (k == 9) start_i = 1'b1;
      if (k == 10) start_i = 1'b0;
      @(negedge clk_i);
    end
    @(negedge clk_i);
    chk("busy_lat", lat, 13);
    chk("busy_nacc", acc_cnt - base, 6);
    chk("busy_rd2_addr", log_addr[base+4], 32'h1C8);
    chk("busy_wr2_addr", log_addr[base+5], 32'h508);
    chk("busy_mem2", mem[32'h142], init_word(32'h72));
    chk("busy_untouched", mem[32'h180], init_word(32'h180));
    chk("busy_idle_after", busy_o, 0);

    // asynchronous reset during WR_REQ of word 2 of 4
    src_addr_i = 32'h300;
    dst_addr_i = 32'h380;
    len_i      = 16'd4;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (obi_req && obi_we && obi_addr == 32'h384) begin
        found = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    chk("rstmid_reached", found, 1);
    rst_ni = 1'b0;
    #1;
    chk("rstmid_req", obi_req, 0);
    chk("rstmid_busy", busy_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rstmid_idle", busy_o, 0);
    chk("rstmid_cycles", cycles_o, 0);
    run_cmd(32'h140, 32'h3C0, 16'd2, 40, lat, e);
    chk("post_rst_lat", lat, 9);
    chk("post_rst_mem0", mem[32'hF0], init_word(32'h50));
    chk("post_rst_mem1", mem[32'hF1], init_word(32'h51));
    chk("post_rst_cycles", cycles_o, PERF ? 32'd9 : 32'd0);
    chk("final_stable", stab_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
